// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared types and limits for the warm-boot sequencer
package warmboot_pkg;

  localparam int WB_MAX_IMAGES = 4;

  typedef logic [1:0] wb_image_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DETACH,
    ST_DRAIN,
    ST_ARM,
    ST_FIRE
  } wb_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler, one-cycle tick on wrap
module ms_tick_gen #(
  parameter int CLK_HZ = 48000000
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - ordered SB_WARMBOOT driver with USB detach and SPI drain
// Optional inactivity auto-boot: WARMBOOT_TIMEOUT_EN.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int NUM_IMAGES    = 4,
  parameter int DEFAULT_IMAGE = 1,
  parameter int CLK_HZ        = 48000000,
  parameter int DETACH_MS     = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_MS    = 5000
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       spi_busy,
  input  logic       usb_activity,
  output logic       usb_detach,
  output logic       busy,
  output logic       img_err,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot
);

`ifdef WARMBOOT_TIMEOUT_EN
  localparam int MS_W = 16;
`else
  localparam int MS_W = 8;
`endif
  localparam wb_image_t DEF_IMG = wb_image_t'(DEFAULT_IMAGE);

  wb_state_t state, state_next;
  wb_image_t image_q, req_image, img_d;
  logic [MS_W-1:0] ms_cnt;
  logic [3:0] settle_cnt;
  logic ms_tick, ms_clear, ms_run;
  logic req_valid, req_accept, auto_req, detach_done, settle_done;
  logic detach_d, busy_d, boot_d;

  assign req_valid = ({1'b0, boot_image} < 3'(NUM_IMAGES));
  assign req_image = (boot_req && req_valid) ? boot_image : DEF_IMG;

`ifdef WARMBOOT_TIMEOUT_EN
  // Activity restarts the whole ms timebase so the timeout is exact from the last strobe.
  assign auto_req = (state == ST_IDLE) && ms_tick && (ms_cnt == MS_W'(TIMEOUT_MS - 1));
  assign ms_clear = req_accept || ((state == ST_IDLE) && usb_activity);
  assign ms_run   = (state == ST_IDLE) || (state == ST_DETACH);
`else
  logic unused_usb_activity;
  assign unused_usb_activity = usb_activity;
  assign auto_req = 1'b0;
  assign ms_clear = req_accept;
  assign ms_run   = (state == ST_DETACH);
`endif

  assign req_accept  = (state == ST_IDLE) && (boot_req || auto_req);
  assign detach_done = ms_tick && (ms_cnt == MS_W'(DETACH_MS - 1));
  assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES - 1));

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .clear     (ms_clear),
    .tick      (ms_tick)
  );

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt     <= '0;
      settle_cnt <= '0;
    end else begin
      if (ms_clear)                ms_cnt <= '0;
      else if (ms_tick && ms_run)  ms_cnt <= ms_cnt + 1'b1;
      if (state != ST_ARM)         settle_cnt <= '0;
      else                         settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      image_q        <= DEF_IMG;
      img_err        <= 1'b0;
      usb_detach     <= 1'b0;
      busy           <= 1'b0;
      wb_boot        <= 1'b0;
      {wb_s1, wb_s0} <= DEF_IMG;
    end else begin
      state          <= state_next;
      usb_detach     <= detach_d;
      busy           <= busy_d;
      wb_boot        <= boot_d;
      {wb_s1, wb_s0} <= img_d;
      if (req_accept) begin
        image_q <= req_image;
        if (boot_req) img_err <= !req_valid;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_accept)  state_next = ST_DETACH;
      ST_DETACH: if (detach_done) state_next = ST_DRAIN;
      ST_DRAIN:  if (!spi_busy)   state_next = ST_ARM;
      ST_ARM:    if (settle_done) state_next = ST_FIRE;
      ST_FIRE:                    state_next = ST_FIRE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    busy_d   = (state_next != ST_IDLE);
    detach_d = (state_next != ST_IDLE);
    boot_d   = (state_next == ST_FIRE);
    img_d    = (state_next == ST_ARM) ? image_q : {wb_s1, wb_s0};
  end

endmodule

// File: doc/warmboot_sequencer.md
# warmboot_sequencer

Parametrised warm-boot controller for the iCE40 bootloader top levels. It accepts an image-select request from the bootloader core, detaches from USB for a programmed time, and waits for SPI flash traffic to drain. It then drives SB_WARMBOOT's S1/S0/BOOT with a glitch-free, ordered sequence. It replaces the fixed S1=0/S0=1 tie-off with a selectable image and an optional inactivity auto-boot.

## Interface
- `NUM_IMAGES`, default 4: number of selectable images, 1..4.
- `DEFAULT_IMAGE`, default 1: image used for invalid requests and auto-boot; must be < `NUM_IMAGES`.
- `CLK_HZ`, default 48000000: frequency of `clk_48mhz`; must be a multiple of 1000.
- `DETACH_MS`, default 10: USB detach time in ms, 1..255.
- `SETTLE_CYCLES`, default 4: cycles S1/S0 are held stable before BOOT rises, 2..15.
- `TIMEOUT_MS`, default 5000: auto-boot timeout in ms; used only with the macro.
- `clk_48mhz`, input, 1: sole clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `boot_req`, input, 1: single-cycle request strobe.
- `boot_image`, input, 2: image index, sampled when `boot_req` is high.
- `spi_busy`, input, 1: bootloader SPI transaction in progress.
- `usb_activity`, input, 1: strobe on any valid USB packet.
- `usb_detach`, output, 1: forces the USB pad OE low and the pull-up off.
- `busy`, output, 1: a sequence is in progress.
- `img_err`, output, 1: sticky flag; the last request had an index ≥ `NUM_IMAGES`.
- `wb_s1`, output, 1: SB_WARMBOOT S1 (image[1]).
- `wb_s0`, output, 1: SB_WARMBOOT S0 (image[0]).
- `wb_boot`, output, 1: SB_WARMBOOT BOOT.

## Operation
- Reset values:
  - `usb_detach`, `busy`, `img_err` and `wb_boot` are 0.
  - {`wb_s1`,`wb_s0`} = `DEFAULT_IMAGE`.
  - State is IDLE; all counters are 0.
- States: IDLE → DETACH → DRAIN → ARM → FIRE.
- IDLE:
  - `boot_req`=1 latches the image. If `boot_image` < `NUM_IMAGES`, it latches `boot_image` and clears `img_err`. Otherwise it latches `DEFAULT_IMAGE` and sets `img_err`.
  - The FSM goes to DETACH and the ms prescaler is cleared.
- DETACH:
  - `usb_detach`=1.
  - The FSM counts `DETACH_MS` ms ticks, then goes to DRAIN.
- DRAIN:
  - `usb_detach` stays 1.
  - The FSM leaves on the first cycle with `spi_busy`=0. There is no timeout.
- ARM:
  - {`wb_s1`,`wb_s0`} = latched image; this value is registered and driven from state entry.
  - The FSM counts `SETTLE_CYCLES` cycles, then goes to FIRE.
- FIRE:
  - `wb_boot`=1 and `usb_detach`=1 are held permanently; the device reconfigures.
  - Only reset leaves FIRE.
- `busy` is 1 in every state except IDLE.
- `boot_req` outside IDLE is ignored: no relatch and no `img_err` update.
- ms tick: a prescaler counts 0..`CLK_HZ`/1000−1 and pulses on wrap. Width is $clog2(`CLK_HZ`/1000). The ms counter is 8 bits without the macro and 16 bits with it.
- `wb_s1`/`wb_s0` never change in the same cycle `wb_boot` rises, and never change while `wb_boot`=1.
- Reset assertion mid-sequence returns everything to reset values immediately (asynchronous).

## Timing
- `boot_req` at cycle N:
  - `busy` and `usb_detach` rise at N+1.
  - DETACH lasts `DETACH_MS`×`CLK_HZ`/1000 cycles ±1.
- DRAIN with `spi_busy`=0 lasts exactly 1 cycle.
- ARM lasts exactly `SETTLE_CYCLES` cycles.
- `wb_boot` rises on the cycle after ARM ends.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `WARMBOOT_TIMEOUT_EN` defined:
  - In IDLE, a ms counter runs from reset. Each `usb_activity` clears it, and it stops permanently after the first `boot_req`.
  - Reaching `TIMEOUT_MS` generates an internal request with `DEFAULT_IMAGE`; `img_err` is unaffected.
  - `boot_req` and the timeout in the same cycle: `boot_req` wins.
- `WARMBOOT_TIMEOUT_EN` undefined: no timeout logic, `usb_activity` is unused, and the ms counter is 8 bits.

## Structure
- Shared package `warmboot_pkg`:
  - state enum (IDLE, DETACH, DRAIN, ARM, FIRE);
  - image index typedef (2 bits);
  - localparam `WB_MAX_IMAGES`=4.
- Sub-module `ms_tick_gen`:
  - parameter `CLK_HZ`;
  - ports: `clk_48mhz`, `reset_n`, `clear`, `tick`.

## Test plan
All scenarios use `CLK_HZ`=48000 (48 cycles/ms), `DETACH_MS`=2, `SETTLE_CYCLES`=4.
- Request `boot_image`=2 with `spi_busy`=0 → `usb_detach` rises at N+1; S1/S0=1/0 from about N+98; `wb_boot` rises at about N+102, after S1/S0 have been stable 4 cycles.
- Request `boot_image`=3 with `NUM_IMAGES`=2 and `DEFAULT_IMAGE`=1 → `img_err`=1 and S1/S0=0/1 at BOOT.
- Hold `spi_busy`=1 for 500 cycles after DETACH → `wb_boot` stays 0 until 4 cycles after `spi_busy` falls, then rises.
- Second `boot_req` with image 0 during DETACH → ignored; the latched image and `img_err` are unchanged.
- Assert `reset_n`=0 during ARM → all outputs return to reset values asynchronously, and a fresh request completes normally.
- `WARMBOOT_TIMEOUT_EN` with `TIMEOUT_MS`=3 and `usb_activity` every 100 cycles → no boot. Stopping activity → auto-boot to `DEFAULT_IMAGE` starts 144±1 cycles after the last strobe.
